psr_bank_ctrl: RTL

//  Parametrised CPSR/SPSR unit with single-clock banked SPSRs and exception entry/return sequencing.

---
 rtl/psr_pkg.sv | 82 ++++++++
 rtl/psr_bank_ctrl_if.sv | 28 ++
 rtl/psr_spsr_reg.sv | 23 ++
 rtl/psr_bank_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// psr_pkg: shared constants, types and helper functions for the CPSR/SPSR unit.
// Build option: PSR_MON_HYP_EN adds the mon and hyp modes with their SPSR banks.
package psr_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    typedef logic [2:0] bank_idx_t;

    localparam bank_idx_t BANK_FIQ = 3'd0;
    localparam bank_idx_t BANK_IRQ = 3'd1;
    localparam bank_idx_t BANK_SVC = 3'd2;
    localparam bank_idx_t BANK_ABT = 3'd3;
    localparam bank_idx_t BANK_UND = 3'd4;

`ifdef PSR_MON_HYP_EN
    localparam logic [4:0] MODE_MON = 5'b10110;
    localparam logic [4:0] MODE_HYP = 5'b11010;
    localparam bank_idx_t  BANK_MON = 3'd5;
    localparam bank_idx_t  BANK_HYP = 3'd6;
    localparam int         NUM_BANKS = 7;
`else
    localparam int         NUM_BANKS = 5;
`endif

    typedef struct packed {
        logic      valid;
        bank_idx_t idx;
    } bank_sel_t;

    typedef enum logic [1:0] {
        CAUSE_FIQ = 2'd0,
        CAUSE_IRQ = 2'd1,
        CAUSE_SVC = 2'd2,
        CAUSE_UND = 2'd3
    } exc_cause_e;

    // Low CPSR byte loaded on entry: mode plus the I/F masks for that exception
    function automatic logic [7:0] entry_cpsr(input exc_cause_e c);
        logic [7:0] v;
        case (c)
            CAUSE_FIQ: v = 8'hD1;
            CAUSE_IRQ: v = 8'h92;
            CAUSE_SVC: v = 8'h93;
            default:   v = 8'h9B;
        endcase
        return v;
    endfunction

    // Which SPSR bank a mode owns; valid=0 for usr, sys and undefined encodings
    function automatic bank_sel_t mode_to_bank(input logic [4:0] m);
        bank_sel_t s;
        s.valid = 1'b1;
        s.idx   = BANK_FIQ;
        case (m)
            MODE_FIQ: s.idx = BANK_FIQ;
            MODE_IRQ: s.idx = BANK_IRQ;
            MODE_SVC: s.idx = BANK_SVC;
            MODE_ABT: s.idx = BANK_ABT;
            MODE_UND: s.idx = BANK_UND;
`ifdef PSR_MON_HYP_EN
            MODE_MON: s.idx = BANK_MON;
            MODE_HYP: s.idx = BANK_HYP;
`endif
            default:  s.valid = 1'b0;
        endcase
        return s;
    endfunction

    // A mode is legal if it is usr/sys or owns a bank in this build
    function automatic logic mode_legal(input logic [4:0] m);
        bank_sel_t s;
        s = mode_to_bank(m);
        return (m == MODE_USR) || (m == MODE_SYS) || s.valid;
    endfunction

endpackage

// File: rtl/psr_bank_ctrl_if.sv
// psr_bank_ctrl_if: control/flag bus between the decode FSM (master) and the PSR unit (slave).
interface psr_bank_ctrl_if #(
    parameter int NUM_EXC = 4
);
    logic [NUM_EXC-1:0] exc_req;
    logic               exc_ack;
    logic [1:0]         exc_cause;
    logic               ret_req;
    logic               msr_we;
    logic               msr_spsr;
    logic [3:0]         msr_mask;
    logic [31:0]        msr_data;
    logic               flag_we;
    logic [3:0]         nzcv;
    logic [31:0]        cpsr;
    logic [31:0]        spsr_cur;
    logic               mode_illegal;

    modport master (
        output exc_req, ret_req, msr_we, msr_spsr, msr_mask, msr_data, flag_we, nzcv,
        input  exc_ack, exc_cause, cpsr, spsr_cur, mode_illegal
    );

    modport slave (
        input  exc_req, ret_req, msr_we, msr_spsr, msr_mask, msr_data, flag_we, nzcv,
        output exc_ack, exc_cause, cpsr, spsr_cur, mode_illegal
    );
endinterface

// File: rtl/psr_spsr_reg.sv
// psr_spsr_reg: one 32-bit saved program status register with byte write enables.
module psr_spsr_reg (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);
    logic [31:0] r_q;

    // Load each enabled byte; clr wipes the whole register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (i_be[k]) r_q[k*8 +: 8] <= i_d[k*8 +: 8];
            end
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/psr_bank_ctrl.sv
// psr_bank_ctrl: CPSR plus banked SPSRs, exception entry/return, MSR and flag updates.
// Build option: PSR_MON_HYP_EN (see psr_pkg) enables the mon/hyp banks.
module psr_bank_ctrl
    import psr_pkg::*;
#(
    parameter int          NUM_EXC    = 4,
    parameter logic [31:0] RESET_CPSR = 32'h0000_0010,
    parameter int          ACK_CYCLES = 1
) (
    input  logic           clk,
    input  logic           clr,
    psr_bank_ctrl_if.slave bus
);
    typedef enum logic {ST_RUN, ST_ACK} state_e;

    localparam logic [1:0] ACK_LAST = 2'(ACK_CYCLES - 1);

    state_e      r_state;
    logic [1:0]  r_ack_cnt;
    logic        r_exc_ack;
    exc_cause_e  r_exc_cause;
    logic [31:0] r_cpsr;
    logic        r_mode_illegal;

    logic [31:0] w_spsr    [NUM_BANKS];
    logic [3:0]  w_bank_be [NUM_BANKS];
    logic [31:0] w_bank_d;
    bank_sel_t   w_cur_sel;
    logic [31:0] w_spsr_cur;
    logic        w_accept;
    exc_cause_e  w_acc_cause;
    logic [31:0] w_cpsr_nxt;
    logic        w_illegal;
    logic [31:0] w_saved;
    logic [7:0]  w_entry_c;
    bank_sel_t   w_entry_sel;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        psr_spsr_reg u_spsr (
            .clk  (clk),
            .clr  (clr),
            .i_be (w_bank_be[b]),
            .i_d  (w_bank_d),
            .o_q  (w_spsr[b])
        );
    end

    // Select the SPSR belonging to the current mode, zero when the mode has none
    always_comb begin
        w_cur_sel  = mode_to_bank(r_cpsr[4:0]);
        w_spsr_cur = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_cur_sel.valid && w_cur_sel.idx == 3'(b)) w_spsr_cur = w_spsr[b];
        end
    end

    // Pick the lowest-index unmasked request; only fiq/irq can be masked
    always_comb begin
        w_accept    = 1'b0;
        w_acc_cause = CAUSE_FIQ;
        if (r_state == ST_RUN) begin
            for (int i = NUM_EXC - 1; i >= 0; i--) begin
                if (bus.exc_req[i] && !((i == 0 && r_cpsr[6]) || (i == 1 && r_cpsr[7]))) begin
                    w_accept    = 1'b1;
                    w_acc_cause = exc_cause_e'(2'(i));
                end
            end
        end
    end

    // Resolve one operation per cycle: entry, then return, then MSR, with flags merged last
    always_comb begin
        w_cpsr_nxt = r_cpsr;
        w_illegal  = 1'b0;
        w_bank_d   = bus.msr_data;
        for (int b = 0; b < NUM_BANKS; b++) w_bank_be[b] = 4'h0;

        w_saved = r_cpsr;
        if (bus.flag_we) w_saved[31:28] = bus.nzcv;
        w_entry_c   = entry_cpsr(w_acc_cause);
        w_entry_sel = mode_to_bank(w_entry_c[4:0]);

        if (w_accept) begin
            w_bank_d = w_saved;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_entry_sel.valid && w_entry_sel.idx == 3'(b)) w_bank_be[b] = 4'hF;
            end
            w_cpsr_nxt[7:0] = w_entry_c;
        end else if (r_state == ST_RUN && bus.ret_req) begin
            if (w_cur_sel.valid) w_cpsr_nxt = w_spsr_cur;
            else                 w_illegal  = 1'b1;
        end else begin
            if (r_state == ST_RUN && bus.msr_we) begin
                if (bus.msr_spsr) begin
                    if (!w_cur_sel.valid) w_illegal = 1'b1;
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (w_cur_sel.valid && w_cur_sel.idx == 3'(b)) w_bank_be[b] = bus.msr_mask;
                    end
                end else begin
                    if (bus.msr_mask[3]) w_cpsr_nxt[31:24] = bus.msr_data[31:24];
                    if (bus.msr_mask[2]) w_cpsr_nxt[23:16] = bus.msr_data[23:16];
                    if (bus.msr_mask[1]) w_cpsr_nxt[15:8]  = bus.msr_data[15:8];
                    if (bus.msr_mask[0] && r_cpsr[4:0] != MODE_USR) begin
                        if (mode_legal(bus.msr_data[4:0])) w_cpsr_nxt[7:0] = bus.msr_data[7:0];
                        else                               w_illegal       = 1'b1;
                    end
                end
            end
            if (bus.flag_we) w_cpsr_nxt[31:28] = bus.nzcv;
        end
    end

    // RUN/ACK sequencer together with the registered CPSR and status outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state        <= ST_RUN;
            r_ack_cnt      <= 2'd0;
            r_exc_ack      <= 1'b0;
            r_exc_cause    <= CAUSE_FIQ;
            r_cpsr         <= RESET_CPSR;
            r_mode_illegal <= 1'b0;
        end else begin
            r_cpsr         <= w_cpsr_nxt;
            r_mode_illegal <= w_illegal;
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_state     <= ST_ACK;
                        r_ack_cnt   <= 2'd0;
                        r_exc_ack   <= 1'b1;
                        r_exc_cause <= w_acc_cause;
                    end
                end
                ST_ACK: begin
                    if (r_ack_cnt == ACK_LAST) begin
                        r_state   <= ST_RUN;
                        r_exc_ack <= 1'b0;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.cpsr         = r_cpsr;
    assign bus.spsr_cur     = w_spsr_cur;
    assign bus.exc_ack      = r_exc_ack;
    assign bus.exc_cause    = r_exc_cause;
    assign bus.mode_illegal = r_mode_illegal;
endmodule
